// File: rtl/baccarat_dealer_fsm.sv
// -----------------------------------------------------------------------------
// baccarat_dealer_fsm
//
// Deals one Baccarat hand. The block owns the card source (a free-running
// 1..CARD_MAX counter) and the six card registers. It hands the cards to two
// external scorehand instances and reads their totals back. It then applies
// the natural, player-third-card and banker-third-card rules, and finally
// decodes the winner.
//
// Ports
//   slow_clock         : single clock for the whole block
//   resetb             : asynchronous active-low reset
//   step               : advance enable; the FSM acts only on edges with step=1
//   pscore, dscore     : player / banker totals from the scorehands (0-9)
//   next_card          : card that the next step will deal
//   pcard1..3/dcard1..3: card registers, 0 = empty
//   player_win         : pscore >= dscore; meaningful only while done=1
//   dealer_win         : dscore >= pscore; meaningful only while done=1
//   done               : hand complete
// -----------------------------------------------------------------------------
module baccarat_dealer_fsm #(
  parameter int CARD_MAX = 13
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [3:0] next_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  typedef enum logic [2:0] {
    S_DEAL_P1,
    S_DEAL_D1,
    S_DEAL_P2,
    S_DEAL_D2,
    S_CHECK,
    S_BANK3,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [3:0] r_cnt;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3;
  logic [3:0] r_dcard1, r_dcard2, r_dcard3;

  logic       w_ld_p1, w_ld_p2, w_ld_p3;
  logic       w_ld_d1, w_ld_d2, w_ld_d3;
  logic       w_clr;
  logic [3:0] w_v3;
  logic       w_bank_draw;

  // Card source. It runs on every edge, whatever the value of step, and
  // wraps from CARD_MAX back to 1.
  // NOTE: sequential state is written with <= so that every flop samples
  // the values that held before the edge.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= 4'd1;
    end else if (r_cnt >= 4'(CARD_MAX)) begin
      r_cnt <= 4'd1;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Face cards (codes 10-13) count as zero in the banker's third-card table.
  assign w_v3 = (r_pcard3 >= 4'd10) ? 4'd0 : r_pcard3;

  // Banker tableau. At this point dscore is still the two-card banker total,
  // because dcard3 is empty while the FSM is in BANK3.
  always_comb begin
    w_bank_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
      4'd3:             w_bank_draw = (w_v3 != 4'd8);
      4'd4:             w_bank_draw = (w_v3 >= 4'd2) && (w_v3 <= 4'd7);
      4'd5:             w_bank_draw = (w_v3 >= 4'd4) && (w_v3 <= 4'd7);
      4'd6:             w_bank_draw = (w_v3 >= 4'd6) && (w_v3 <= 4'd7);
      default:          w_bank_draw = 1'b0;
    endcase
  end

  // Next-state, load strobes and DONE decodes. The load strobes only name
  // the register to fill; they take effect on an edge only when step=1.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_ld_p1      = 1'b0;
    w_ld_p2      = 1'b0;
    w_ld_p3      = 1'b0;
    w_ld_d1      = 1'b0;
    w_ld_d2      = 1'b0;
    w_ld_d3      = 1'b0;
    w_clr        = 1'b0;
    done         = 1'b0;
    player_win   = 1'b0;
    dealer_win   = 1'b0;
    case (r_state)
      S_DEAL_P1: begin
        w_ld_p1      = 1'b1;
        w_next_state = S_DEAL_D1;
      end
      S_DEAL_D1: begin
        w_ld_d1      = 1'b1;
        w_next_state = S_DEAL_P2;
      end
      S_DEAL_P2: begin
        w_ld_p2      = 1'b1;
        w_next_state = S_DEAL_D2;
      end
      S_DEAL_D2: begin
        w_ld_d2      = 1'b1;
        w_next_state = S_CHECK;
      end
      S_CHECK: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          w_next_state = S_DONE;
        end else if (pscore <= 4'd5) begin
          w_ld_p3      = 1'b1;
          w_next_state = S_BANK3;
        end else begin
          w_ld_d3      = (dscore <= 4'd5);
          w_next_state = S_DONE;
        end
      end
      S_BANK3: begin
        w_ld_d3      = w_bank_draw;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        player_win   = (pscore >= dscore);
        dealer_win   = (dscore >= pscore);
        w_clr        = 1'b1;
        w_next_state = S_DEAL_P1;
      end
      default: begin
        w_next_state = S_DEAL_P1;
      end
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_DEAL_P1;
    end else if (step) begin
      r_state <= w_next_state;
    end
  end

  // Card registers. Each one is written at most once per hand: the FSM
  // visits each load state once, and only the DONE clear empties them.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_pcard1 <= 4'd0;
      r_pcard2 <= 4'd0;
      r_pcard3 <= 4'd0;
      r_dcard1 <= 4'd0;
      r_dcard2 <= 4'd0;
      r_dcard3 <= 4'd0;
    end else if (step) begin
      if (w_clr) begin
        r_pcard1 <= 4'd0;
        r_pcard2 <= 4'd0;
        r_pcard3 <= 4'd0;
        r_dcard1 <= 4'd0;
        r_dcard2 <= 4'd0;
        r_dcard3 <= 4'd0;
      end else begin
        if (w_ld_p1) r_pcard1 <= r_cnt;
        if (w_ld_p2) r_pcard2 <= r_cnt;
        if (w_ld_p3) r_pcard3 <= r_cnt;
        if (w_ld_d1) r_dcard1 <= r_cnt;
        if (w_ld_d2) r_dcard2 <= r_cnt;
        if (w_ld_d3) r_dcard3 <= r_cnt;
      end
    end
  end

  assign next_card = r_cnt;
  assign pcard1    = r_pcard1;
  assign pcard2    = r_pcard2;
  assign pcard3    = r_pcard3;
  assign dcard1    = r_dcard1;
  assign dcard2    = r_dcard2;
  assign dcard3    = r_dcard3;

endmodule
